// File: rtl/polytris_pkg.sv
// Shared board geometry, row type and line-clear engine state encoding.
package polytris_pkg;
    localparam int ROWS   = 30;
    localparam int COLS   = 16;
    localparam int CELL_W = 2;
    localparam int DATA_W = 32;
    localparam int ROW_AW = $clog2(ROWS);

    typedef logic [DATA_W-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT,
        WIPE
    } bs_state_t;
endpackage

// File: rtl/full_row_detect.sv
// Flags a row whose every cell has at least one bit set; bits above the cell field are ignored.
module full_row_detect
    import polytris_pkg::*;
(
    input  row_t row,
    output logic full
);
    logic [COLS-1:0] occ;

    always_comb begin
        occ = '0;
        for (int c = 0; c < COLS; c++) begin
            occ[c] = |row[c*CELL_W +: CELL_W];
        end
    end

    assign full = &occ;
endmodule

// File: rtl/board_store.sv
// Board row memory with masked writes, 1-cycle reads, line-clear engine and full wipe.
// Optional macro BOARD_STORE_TOTAL_EN adds the TOTAL_LINES running counter.
module board_store
    import polytris_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [10:0]         RAM_ROW_ADDR,
    input  logic                RAM_WE,
    input  logic                RAM_RE,
    input  logic [31:0]         RAM_WRITEDATA,
    input  logic [15:0]         RAM_CELLMASK,
    output logic [31:0]         RAM_READDATA,
    output logic                RAM_RVALID,
    input  logic                CLEAR_REQ,
    input  logic                CLEARALL_REQ,
    output logic                BUSY,
    output logic                CLEAR_DONE,
    output logic [2:0]          LINES_CLEARED,
    output row_t [ROWS-1:0]     BOARD_DATA
`ifdef BOARD_STORE_TOTAL_EN
    ,
    output logic [15:0]         TOTAL_LINES
`endif
);
    localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);
    localparam logic [ROW_AW-1:0] ONE      = ROW_AW'(1);

    bs_state_t         state;
    row_t [ROWS-1:0]   rows_q;
    row_t              rd_data_p1;
    logic              rvld_p1;
    logic              busy_q;
    logic              done_q;
    logic [2:0]        lines_q;
    logic [ROW_AW-1:0] scan_row;
    logic [ROW_AW-1:0] shift_row;
    logic [ROW_AW-1:0] wipe_row;
    logic              row_full;
    logic              addr_ok;
    logic [ROW_AW-1:0] addr_idx;
`ifdef BOARD_STORE_TOTAL_EN
    logic [15:0]       total_q;
`endif

    function automatic row_t merge_row(input row_t old_row, input row_t wdata,
                                       input logic [COLS-1:0] mask);
        row_t res;
        res = old_row;
        for (int c = 0; c < COLS; c++) begin
            if (mask[c]) res[c*CELL_W +: CELL_W] = wdata[c*CELL_W +: CELL_W];
        end
        return res;
    endfunction

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    assign addr_ok  = (RAM_ROW_ADDR < 11'(ROWS));
    assign addr_idx = RAM_ROW_ADDR[ROW_AW-1:0];

    full_row_detect u_detect (
        .row  (rows_q[scan_row]),
        .full (row_full)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            rows_q     <= '0;
            rd_data_p1 <= '0;
            rvld_p1    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            lines_q    <= '0;
            scan_row   <= '0;
            shift_row  <= '0;
            wipe_row   <= '0;
`ifdef BOARD_STORE_TOTAL_EN
            total_q    <= '0;
`endif
        end else begin
            done_q  <= 1'b0;
            rvld_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    // Read samples the row before any same-cycle write lands.
                    if (RAM_RE) begin
                        rvld_p1    <= 1'b1;
                        rd_data_p1 <= addr_ok ? rows_q[addr_idx] : '0;
                    end
                    if (RAM_WE && addr_ok) begin
                        rows_q[addr_idx] <= merge_row(rows_q[addr_idx], RAM_WRITEDATA, RAM_CELLMASK);
                    end
                    if (CLEARALL_REQ) begin
                        state    <= WIPE;
                        busy_q   <= 1'b1;
                        wipe_row <= '0;
                        lines_q  <= '0;
                    end else if (CLEAR_REQ) begin
                        state    <= SCAN;
                        busy_q   <= 1'b1;
                        scan_row <= LAST_ROW;
                        lines_q  <= '0;
                    end
                end
                SCAN: begin
                    // The detecting cycle already performs the first shift step.
                    if (row_full) begin
                        if (scan_row == '0) begin
                            rows_q[0] <= '0;
                            lines_q   <= sat_inc(lines_q);
                        end else begin
                            rows_q[scan_row] <= rows_q[scan_row - ONE];
                            shift_row        <= scan_row - ONE;
                            state            <= SHIFT;
                        end
                    end else if (scan_row == '0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
`ifdef BOARD_STORE_TOTAL_EN
                        total_q <= total_q + 16'(lines_q);
`endif
                    end else begin
                        scan_row <= scan_row - ONE;
                    end
                end
                SHIFT: begin
                    if (shift_row == '0) begin
                        rows_q[0] <= '0;
                        lines_q   <= sat_inc(lines_q);
                        state     <= SCAN;
                    end else begin
                        rows_q[shift_row] <= rows_q[shift_row - ONE];
                        shift_row         <= shift_row - ONE;
                    end
                end
                WIPE: begin
                    rows_q[wipe_row] <= '0;
                    if (wipe_row == LAST_ROW) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        lines_q <= '0;
`ifdef BOARD_STORE_TOTAL_EN
                        total_q <= '0;
`endif
                    end else begin
                        wipe_row <= wipe_row + ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign RAM_READDATA  = rd_data_p1;
    assign RAM_RVALID    = rvld_p1;
    assign BUSY          = busy_q;
    assign CLEAR_DONE    = done_q;
    assign LINES_CLEARED = lines_q;
    assign BOARD_DATA    = rows_q;
`ifdef BOARD_STORE_TOTAL_EN
    assign TOTAL_LINES   = total_q;
`endif
endmodule

// File: tb/tb_board_store.sv
// Scoreboard bench for board_store: random row traffic and clear passes against a row-list model.
module tb_board_store;
    import polytris_pkg::*;

    logic            CLK = 1'b0;
    logic            RESET_N;
    logic [10:0]     RAM_ROW_ADDR;
    logic            RAM_WE;
    logic            RAM_RE;
    logic [31:0]     RAM_WRITEDATA;
    logic [15:0]     RAM_CELLMASK;
    logic [31:0]     RAM_READDATA;
    logic            RAM_RVALID;
    logic            CLEAR_REQ;
    logic            CLEARALL_REQ;
    logic            BUSY;
    logic            CLEAR_DONE;
    logic [2:0]      LINES_CLEARED;
    row_t [ROWS-1:0] BOARD_DATA;
`ifdef BOARD_STORE_TOTAL_EN
    logic [15:0]     TOTAL_LINES;
`endif

    board_store dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .RAM_ROW_ADDR  (RAM_ROW_ADDR),
        .RAM_WE        (RAM_WE),
        .RAM_RE        (RAM_RE),
        .RAM_WRITEDATA (RAM_WRITEDATA),
        .RAM_CELLMASK  (RAM_CELLMASK),
        .RAM_READDATA  (RAM_READDATA),
        .RAM_RVALID    (RAM_RVALID),
        .CLEAR_REQ     (CLEAR_REQ),
        .CLEARALL_REQ  (CLEARALL_REQ),
        .BUSY          (BUSY),
        .CLEAR_DONE    (CLEAR_DONE),
        .LINES_CLEARED (LINES_CLEARED),
        .BOARD_DATA    (BOARD_DATA)
`ifdef BOARD_STORE_TOTAL_EN
        ,
        .TOTAL_LINES   (TOTAL_LINES)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int lines;
        int lat;
        int start;
    } done_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          eng_busy = 0;
    int          total_m = 0;
    row_t        m [ROWS];
    logic [31:0] rd_q [$];
    done_t       done_q [$];
    done_t       d_mon;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_full(input row_t v);
        for (int c = 0; c < COLS; c++) begin
            if (v[2*c +: 2] == 2'b00) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check_board(input string name);
        int bad;
        bad = -1;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (BOARD_DATA[i] !== m[i]) bad = i;
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s: row %0d got %08h expected %08h", name, bad, BOARD_DATA[bad], m[bad]);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents read data or a done pulse.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (RAM_RVALID === 1'b1) begin
                if (rd_q.size() == 0) chk("unexpected_rvalid", 64'(1), 64'(0));
                else chk("read_data", 64'(RAM_READDATA), 64'(rd_q.pop_front()));
            end
            if (CLEAR_DONE === 1'b1) begin
                if (done_q.size() == 0) chk("unexpected_done", 64'(1), 64'(0));
                else begin
                    d_mon = done_q.pop_front();
                    chk("lines_cleared", 64'(LINES_CLEARED), 64'(d_mon.lines));
                    chk("done_latency", 64'(cyc - d_mon.start), 64'(d_mon.lat));
                end
            end
        end
    end

    task automatic op(input bit we, input bit re, input int addr,
                      input logic [31:0] data, input logic [15:0] mask);
        @(negedge CLK);
        RAM_WE        = we;
        RAM_RE        = re;
        RAM_ROW_ADDR  = 11'(addr);
        RAM_WRITEDATA = data;
        RAM_CELLMASK  = mask;
        if (!eng_busy) begin
            if (re) rd_q.push_back(addr < ROWS ? m[addr] : 32'h0);
            if (we && addr < ROWS) begin
                for (int c = 0; c < COLS; c++) begin
                    if (mask[c]) m[addr][2*c +: 2] = data[2*c +: 2];
                end
            end
        end
    endtask

    task automatic release_bus();
        @(negedge CLK);
        RAM_WE = 1'b0;
        RAM_RE = 1'b0;
    endtask

    task automatic model_clear();
        int   below;
        int   lat;
        int   j;
        int   lines;
        row_t nb [ROWS];
        below = 0;
        lat   = ROWS;
        // A full row is found at its original index pushed down by every full row removed beneath it.
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (is_full(m[i])) begin
                lat += i + below + 1;
                below++;
            end
        end
        for (int i = 0; i < ROWS; i++) nb[i] = '0;
        j = ROWS - 1;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!is_full(m[i])) begin
                nb[j] = m[i];
                j--;
            end
        end
        m       = nb;
        lines   = (below > 7) ? 7 : below;
        total_m = (total_m + lines) % 65536;
        done_q.push_back('{lines: lines, lat: lat, start: cyc + 1});
    endtask

    task automatic start_clear(input bit clr, input bit all);
        @(negedge CLK);
        CLEAR_REQ    = clr;
        CLEARALL_REQ = all;
        eng_busy     = 1'b1;
        if (all) begin
            for (int i = 0; i < ROWS; i++) m[i] = '0;
            total_m = 0;
            done_q.push_back('{lines: 0, lat: ROWS, start: cyc + 1});
        end else begin
            model_clear();
        end
        @(negedge CLK);
        CLEAR_REQ    = 1'b0;
        CLEARALL_REQ = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (BUSY === 1'b1 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 3000) chk("busy_timeout", 64'(1), 64'(0));
        eng_busy = 1'b0;
        @(negedge CLK);
        check_board(name);
`ifdef BOARD_STORE_TOTAL_EN
        chk("total_lines", 64'(TOTAL_LINES), 64'(total_m));
`endif
    endtask

    function automatic logic [31:0] full_pattern();
        logic [31:0] v;
        v = $urandom;
        for (int c = 0; c < COLS; c++) v[2*c +: 2] = 2'($urandom_range(1, 3));
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0;
        RAM_WE = 1'b0; RAM_RE = 1'b0; RAM_ROW_ADDR = '0;
        RAM_WRITEDATA = '0; RAM_CELLMASK = '0;
        CLEAR_REQ = 1'b0; CLEARALL_REQ = 1'b0;
        for (int i = 0; i < ROWS; i++) m[i] = '0;
        repeat (3) @(negedge CLK);
        chk("reset_busy", 64'(BUSY), 64'(0));
        chk("reset_rvalid", 64'(RAM_RVALID), 64'(0));
        chk("reset_readdata", 64'(RAM_READDATA), 64'(0));
        chk("reset_done", 64'(CLEAR_DONE), 64'(0));
        chk("reset_lines", 64'(LINES_CLEARED), 64'(0));
        check_board("reset_board");
        RESET_N = 1'b1;

        op(1'b0, 1'b1, 5, 32'h0, 16'h0);
        release_bus();
        check_board("board_after_read");

        op(1'b1, 1'b0, 3, 32'hFFFF_FFFF, 16'h00F0);
        release_bus();
        chk("row3_first", 64'(BOARD_DATA[3]), 64'(32'h0000_FF00));
        op(1'b1, 1'b0, 3, 32'h0, 16'h0010);
        release_bus();
        chk("row3_second", 64'(BOARD_DATA[3]), 64'(32'h0000_FC00));
        op(1'b1, 1'b1, 3, 32'hFFFF_FFFF, 16'hFFFF);
        op(1'b1, 1'b1, 40, 32'hFFFF_FFFF, 16'hFFFF);
        release_bus();
        check_board("write_read_same_row");

        start_clear(1'b0, 1'b1);
        wait_idle("wipe_board");

        op(1'b1, 1'b0, 29, 32'h5555_5555, 16'hFFFF);
        op(1'b1, 1'b0, 28, 32'h5555_5555, 16'hFFFF);
        op(1'b1, 1'b0, 27, 32'h0000_0003, 16'hFFFF);
        release_bus();
        start_clear(1'b1, 1'b0);
        wait_idle("two_line_clear");
        chk("row29_after_clear", 64'(BOARD_DATA[29]), 64'(32'h0000_0003));

        start_clear(1'b0, 1'b1);
        wait_idle("wipe_before_empty");
        start_clear(1'b1, 1'b0);
        op(1'b1, 1'b1, 12, 32'hFFFF_FFFF, 16'hFFFF);
        op(1'b1, 1'b0, 29, 32'hFFFF_FFFF, 16'hFFFF);
        release_bus();
        wait_idle("empty_clear_busy_writes");

        for (int round = 0; round < 5; round++) begin
            if (round == 4) begin
                for (int a = 20; a < ROWS; a++) op(1'b1, 1'b0, a, full_pattern(), 16'hFFFF);
            end
            for (int n = 0; n < 50; n++) begin
                if ($urandom_range(0, 3) == 0)
                    op(1'b1, $urandom_range(0, 3) == 0, $urandom_range(0, 33), full_pattern(), 16'hFFFF);
                else
                    op($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 33),
                       $urandom, 16'($urandom));
            end
            release_bus();
            start_clear(1'b1, 1'b0);
            wait_idle("random_clear");
        end

        for (int a = 0; a < ROWS; a++) op(1'b1, 1'b0, a, $urandom, 16'($urandom));
        release_bus();
        start_clear(1'b1, 1'b1);
        wait_idle("both_requests_wipe");

        op(1'b1, 1'b0, 29, 32'hFFFF_FFFF, 16'hFFFF);
        op(1'b1, 1'b0, 10, 32'h0000_0F0F, 16'hFFFF);
        release_bus();
        start_clear(1'b1, 1'b0);
        repeat (4) @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        done_q.delete();
        for (int i = 0; i < ROWS; i++) m[i] = '0;
        total_m  = 0;
        eng_busy = 1'b0;
        chk("midpass_reset_busy", 64'(BUSY), 64'(0));
        chk("midpass_reset_done", 64'(CLEAR_DONE), 64'(0));
        check_board("midpass_reset_board");
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        op(1'b0, 1'b1, 10, 32'h0, 16'h0);
        release_bus();
        repeat (40) @(negedge CLK);
        check_board("after_reset_idle");

        chk("pending_reads", 64'(rd_q.size()), 64'(0));
        chk("pending_done", 64'(done_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/board_store.md
Name: board_store

Overview:
- Board memory responder on the far side of the gameboard's RAM row interface (RAM_ROW_ADDR / RAM_WE / RAM_RE).
- Holds ROWS x 32-bit rows, with 2 bits per cell and 16 cells; serves masked row writes and 1-cycle row reads.
- Drives the continuous BOARD_DATA view consumed by collision logic and the renderer.
- Owns the sequential line-clear engine (scan, shift-down, count) and the clear-all wipe.

Parameters:
ROWS, 30, number of board rows; row 0 is top.
COLS, 16, cells per row.
CELL_W, 2, bits per cell; a cell is occupied if any of its bits is 1.

Ports:
CLK  in  1  system clock, rising edge.
RESET_N  in  1  asynchronous active-low reset.
RAM_ROW_ADDR  in  11  row address; values >= ROWS are out of range.
RAM_WE  in  1  masked row write strobe.
RAM_RE  in  1  row read strobe.
RAM_WRITEDATA  in  32  write row data.
RAM_CELLMASK  in  16  per-cell write enable; bit c covers data bits [2c+1:2c].
RAM_READDATA  out  32  read data.
RAM_RVALID  out  1  read data valid, 1-cycle pulse.
CLEAR_REQ  in  1  start a line-clear pass (pulse).
CLEARALL_REQ  in  1  start a full-board wipe (pulse).
BUSY  out  1  engine active; RAM port ignored.
CLEAR_DONE  out  1  1-cycle pulse at the end of a clear pass or wipe.
LINES_CLEARED  out  3  lines removed by the last pass; valid with CLEAR_DONE and held until the next pass.
BOARD_DATA  out  ROWS x 32  registered view of all rows.

Behaviour:
- Reset (async, RESET_N low):
  - All rows 0; FSM in IDLE.
  - RAM_READDATA=0, RAM_RVALID=0, BUSY=0, CLEAR_DONE=0, LINES_CLEARED=0.
  - Reset mid-pass aborts the pass with no CLEAR_DONE.
- Write (IDLE only):
  - RAM_WE=1 with an in-range address updates only the masked cells at the clock edge.
  - Visible on BOARD_DATA the next cycle.
  - Out-of-range writes are dropped.
- Read (IDLE only):
  - RAM_RE=1 gives RAM_READDATA and RAM_RVALID=1 on the next cycle.
  - Out-of-range reads return 0 with RVALID=1.
  - RE and WE to the same row in the same cycle: read returns pre-write data.
- FSM states: IDLE, SCAN, SHIFT, WIPE.
  - IDLE -> WIPE on CLEARALL_REQ.
    - CLEARALL_REQ wins if it is asserted in the same cycle as CLEAR_REQ.
  - IDLE -> SCAN on CLEAR_REQ.
    - Pointer r=ROWS-1; LINES_CLEARED counter reset to 0.
  - SCAN, one row per cycle:
    - If row r is full (all COLS cells occupied): go to SHIFT with k=r.
    - Else if r==0: go to IDLE and pulse CLEAR_DONE.
    - Else r=r-1.
  - SHIFT, one row per cycle: row[k] <= row[k-1]; k=k-1.
    - At k==0: row[0] <= 0, counter +1 (saturating at 7), return to SCAN at the same r, because the new row r must be rechecked.
  - WIPE: zero row w per cycle for w = 0..ROWS-1, then IDLE with CLEAR_DONE and LINES_CLEARED=0.
    - Takes exactly ROWS cycles.
- BUSY=1 in SCAN, SHIFT and WIPE.
  - While BUSY: RAM_WE and RAM_RE are ignored, RAM_RVALID stays 0, and CLEAR_REQ/CLEARALL_REQ are ignored.
- Clear-pass timing: an empty board takes ROWS cycles of SCAN; each cleared line found at row r adds r+1 SHIFT cycles.
- Bits above 2*COLS-1 of each row are preserved by writes and ignored by full-row detection.

Optional Feature:
- Macro: BOARD_STORE_TOTAL_EN.
- Defined: adds output TOTAL_LINES [15:0].
  - Reset to 0; incremented by LINES_CLEARED at each clear-pass CLEAR_DONE; wraps modulo 2^16.
  - Zeroed on WIPE completion.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package polytris_pkg holds:
  - ROWS, COLS, CELL_W constants.
  - typedef row_t (logic [31:0]).
  - enum bs_state_t {IDLE, SCAN, SHIFT, WIPE}.
- Sub-module full_row_detect: combinational row_t -> full flag, OR-reducing each cell's bit pair and AND-ing across COLS.

Test Plan:
- Reset then read address 5 -> RAM_READDATA=0 and RAM_RVALID=1 one cycle after RE; BOARD_DATA all zero.
- Write row 3 = 32'hFFFF_FFFF with mask 16'h00F0 -> row 3 = 32'h0000_FF00; then write 32'h0 with mask 16'h0010 -> row 3 = 32'h0000_FC00.
- Rows 29 and 28 full (32'h5555_5555), row 27 = 32'h0000_0003, CLEAR_REQ:
  - Row 29 = 32'h0000_0003, rows 0-28 = 0.
  - LINES_CLEARED=2 with CLEAR_DONE after 30+30+30 = 90 cycles.
- CLEAR_REQ on an empty board -> CLEAR_DONE after 30 cycles, LINES_CLEARED=0; RAM_WE issued during BUSY leaves the board unchanged.
- CLEAR_REQ and CLEARALL_REQ in the same cycle with random contents -> WIPE; all rows 0 after 30 cycles; CLEAR_DONE; with BOARD_STORE_TOTAL_EN, TOTAL_LINES=0.
- RESET_N asserted mid-SHIFT -> immediate zero board, BUSY=0, no CLEAR_DONE; a following read of row 10 returns 0.
